// File: rtl/vga_tile_render_if.sv
// Board RAM read bus between the tile renderer (master) and the board RAM (slave).
// The RAM is synchronous-read: mem_rdata reflects mem_addr one clock later.
interface vga_tile_render_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/vga_tile_render.sv
// vga_tile_render: pixel stage behind the VGA timing generator. Tracks which
// board cell the current pixel falls in, reads that cell's code from the
// board RAM, and drives registered 12-bit RGB with syncs delayed to match.
// Also produces a one-clock frame tick at the start of vertical blank.
module vga_tile_render #(
  parameter int CELL_PX   = 20,
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int ADDR_W    = 10,
  parameter int SHOW_GRID = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  vga_tile_render_if.master board,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_tick
);

  localparam int SUB_W = $clog2(CELL_PX);
  localparam int CX_W  = $clog2(GRID_W);
  localparam int CY_W  = $clog2(GRID_H);

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
  localparam logic [CX_W-1:0]  CX_LAST  = CX_W'(GRID_W - 1);
  localparam logic [CY_W-1:0]  CY_LAST  = CY_W'(GRID_H - 1);
  // First line of vertical blank (one past the last visible line).
  localparam logic [9:0]       V_BLANK  = 10'(GRID_H * CELL_PX);

  // Stage 1 state: position inside the cell and the cell coordinates.
  logic [SUB_W-1:0] sub_x_r, sub_y_r;
  logic [CX_W-1:0]  cx_r;
  logic [CY_W-1:0]  cy_r;
  logic [SUB_W-1:0] sub_x_s, sub_y_s;
  logic [CX_W-1:0]  cx_s;
  logic [CY_W-1:0]  cy_s;
  logic             e1_s;

  // Stage 1 delayed flags.
  logic e1_r, de1_r, hs1_r, vs1_r;
  // Stage 2: captured cell code and flags.
  logic [2:0] code2_r;
  logic       e2_r, de2_r, hs2_r, vs2_r;

  // Map a cell code to its colour; blanking and grid lines handled here.
  function automatic logic [11:0] cell_colour(input logic [2:0] code,
                                              input logic       on_edge,
                                              input logic       visible);
    logic [11:0] c;
    if (!visible) begin
      c = 12'h000;
    end else begin
      case (code)
        3'd0:    c = ((SHOW_GRID != 0) && on_edge) ? 12'h222 : 12'h000;
        3'd1:    c = 12'h0C0;
        3'd2:    c = 12'h0F4;
        3'd3:    c = 12'hF20;
        3'd4:    c = 12'h88F;
        default: c = 12'hF0F;
      endcase
    end
    return c;
  endfunction

  // Next cell position: restart on line/frame start, step and wrap otherwise,
  // holding the last cell through blanking so the address stays in range.
  always_comb begin
    sub_x_s = sub_x_r;
    cx_s    = cx_r;
    sub_y_s = sub_y_r;
    cy_s    = cy_r;
    if (hcount == 10'd0) begin
      sub_x_s = {SUB_W{1'b0}};
      cx_s    = {CX_W{1'b0}};
      if (vcount == 10'd0) begin
        sub_y_s = {SUB_W{1'b0}};
        cy_s    = {CY_W{1'b0}};
      end else if (sub_y_r == SUB_LAST) begin
        sub_y_s = {SUB_W{1'b0}};
        cy_s    = (cy_r == CY_LAST) ? cy_r : cy_r + CY_W'(1);
      end else begin
        sub_y_s = sub_y_r + SUB_W'(1);
      end
    end else if (sub_x_r == SUB_LAST) begin
      sub_x_s = {SUB_W{1'b0}};
      cx_s    = (cx_r == CX_LAST) ? cx_r : cx_r + CX_W'(1);
    end else begin
      sub_x_s = sub_x_r + SUB_W'(1);
    end
    e1_s = (sub_x_s == {SUB_W{1'b0}}) || (sub_y_s == {SUB_W{1'b0}});
  end

  // Stage 1: commit cell position, issue the RAM address, delay timing flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_x_r        <= {SUB_W{1'b0}};
      sub_y_r        <= {SUB_W{1'b0}};
      cx_r           <= {CX_W{1'b0}};
      cy_r           <= {CY_W{1'b0}};
      board.mem_addr <= {ADDR_W{1'b0}};
      e1_r           <= 1'b0;
      de1_r          <= 1'b0;
      hs1_r          <= 1'b1;
      vs1_r          <= 1'b1;
    end else if (pix_en) begin
      sub_x_r        <= sub_x_s;
      sub_y_r        <= sub_y_s;
      cx_r           <= cx_s;
      cy_r           <= cy_s;
      board.mem_addr <= ADDR_W'({cy_s, cx_s});
      e1_r           <= e1_s;
      de1_r          <= de_in;
      hs1_r          <= hsync_in;
      vs1_r          <= vsync_in;
    end
  end

  // Stage 2: capture the cell code returned by the RAM alongside its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code2_r <= 3'd0;
      e2_r    <= 1'b0;
      de2_r   <= 1'b0;
      hs2_r   <= 1'b1;
      vs2_r   <= 1'b1;
    end else if (pix_en) begin
      code2_r <= board.mem_rdata;
      e2_r    <= e1_r;
      de2_r   <= de1_r;
      hs2_r   <= hs1_r;
      vs2_r   <= vs1_r;
    end
  end

  // Stage 3: decode colour into the output registers with matching syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (pix_en) begin
      {vga_r, vga_g, vga_b} <= cell_colour(code2_r, e2_r, de2_r);
      vga_hs <= hs2_r;
      vga_vs <= vs2_r;
    end
  end

  // Frame tick: one clock after the step that starts vertical blank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick <= 1'b0;
    end else if (pix_en && (hcount == 10'd0) && (vcount == V_BLANK)) begin
      frame_tick <= 1'b1;
    end else begin
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_tile_render.sv
// Bench for vga_tile_render: drives shortened-line frames (full-width lines
// only where needed), models the board RAM, and compares every clock against
// a coordinate-based reference plus hand-computed literal pins.
module tb_vga_tile_render;

  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic [9:0] hcount, vcount;
  logic       de_in, hsync_in, vsync_in;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_tick;

  vga_tile_render_if #(.ADDR_W(10)) bus ();

  vga_tile_render #(
    .CELL_PX(20), .GRID_W(32), .GRID_H(24), .ADDR_W(10), .SHOW_GRID(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .board(bus),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM: synchronous read.
  logic [2:0] mem [0:1023];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  int total = 0;
  int bad   = 0;

  // Reference state: pending {hs,vs,rgb} per sample and the sample's (h,v) tag.
  logic [13:0] exp_q[$];
  int          tag_q[$];
  logic [9:0]  exp_addr;
  logic        exp_tick;
  logic        chk_en;
  int          frame_id, step_cnt, tick_cnt, hs_low, vs_low;
  int          hs_in_fall, hs_out_fall, hs_out_rise;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tg(input int h, input int v);
    return h * 1024 + v;
  endfunction

  // Colour a pixel must have, straight from its screen coordinates.
  function automatic logic [11:0] ref_colour(input int h, input int v);
    logic [2:0] code;
    if (h >= 640 || v >= 480) return 12'h000;
    code = mem[(v / 20) * 32 + (h / 20)];
    case (code)
      3'd0:    return ((h % 20 == 0) || (v % 20 == 0)) ? 12'h222 : 12'h000;
      3'd1:    return 12'h0C0;
      3'd2:    return 12'h0F4;
      3'd3:    return 12'hF20;
      3'd4:    return 12'h88F;
      default: return 12'hF0F;
    endcase
  endfunction

  function automatic int ref_addr(input int h, input int v);
    int cx, cy;
    cx = (h / 20 > 31) ? 31 : h / 20;
    cy = (v / 20 > 23) ? 23 : v / 20;
    return cy * 32 + cx;
  endfunction

  task automatic model_reset();
    exp_q    = '{14'h3000, 14'h3000, 14'h3000};
    tag_q    = '{-1, -1, -1};
    exp_addr = 10'd0;
    exp_tick = 1'b0;
  endtask

  // Literal pins on what the outputs show after each pixel step.
  task automatic observe(input int h, input int v, input logic hs);
    int t;
    logic [11:0] rgb;
    t   = tag_q[0];
    rgb = {vga_r, vga_g, vga_b};
    if (vga_hs === 1'b0) hs_low++;
    if (vga_vs === 1'b0) vs_low++;
    if (!hs && hs_in_fall < 0) hs_in_fall = step_cnt;
    if (vga_hs === 1'b0 && hs_out_fall < 0) hs_out_fall = step_cnt;
    if (vga_hs === 1'b1 && hs_out_fall >= 0 && hs_out_rise < 0) hs_out_rise = step_cnt;
    if (h == 25 && v == 45)   check("addr_25_45", 32'(bus.mem_addr), 32'd65);
    if (h == 639 && v == 479) check("addr_639_479", 32'(bus.mem_addr), 32'd767);
    if (h == 700 && v == 479) check("addr_sat_700_479", 32'(bus.mem_addr), 32'd767);
    if (frame_id == 1) begin
      if (t == tg(5, 5))     check("rgb_code6_5_5", 32'(rgb), 32'h0F0F);
      if (t == tg(20, 5))    check("rgb_grid_20_5", 32'(rgb), 32'h0222);
      if (t == tg(21, 5))    check("rgb_empty_21_5", 32'(rgb), 32'h0000);
      if (t == tg(20, 45))   check("rgb_head_20_45", 32'(rgb), 32'h00F4);
      if (t == tg(25, 45))   check("rgb_head_25_45", 32'(rgb), 32'h00F4);
      if (t == tg(639, 479)) check("rgb_food_639_479", 32'(rgb), 32'h0F20);
    end else begin
      if (t == tg(20, 5))    check("rgb_wall_20_5", 32'(rgb), 32'h088F);
      if (t == tg(100, 479)) check("rgb_wall_100_479", 32'(rgb), 32'h088F);
      if (t == tg(640, 479)) check("rgb_hblank_640", 32'(rgb), 32'h0000);
      if (t == tg(10, 480))  check("rgb_vblank_10_480", 32'(rgb), 32'h0000);
    end
  endtask

  // One pixel step: present inputs, take the pix_en edge, update the reference.
  task automatic pix_step(input int h, input int v, input logic hs, input logic vs,
                          input int period);
    logic [13:0] e;
    hcount   = 10'(h);
    vcount   = 10'(v);
    de_in    = (h < 640 && v < 480);
    hsync_in = hs;
    vsync_in = vs;
    pix_en   = 1'b1;
    e = {hs, vs, ref_colour(h, v)};
    @(posedge clk);
    exp_q.push_back(e);
    exp_q.delete(0);
    tag_q.push_back(tg(h, v));
    tag_q.delete(0);
    exp_addr = 10'(ref_addr(h, v));
    exp_tick = (h == 0 && v == 480);
    step_cnt++;
    #1;
    pix_en = 1'b0;
    if (frame_id > 0) observe(h, v, hs);
    for (int i = 1; i < period; i++) begin
      @(posedge clk);
      exp_tick = 1'b0;
    end
    #1;
  endtask

  task automatic run_frame(input int period, input int fid);
    int len;
    frame_id    = fid;
    tick_cnt    = 0;
    hs_low      = 0;
    vs_low      = 0;
    hs_in_fall  = -1;
    hs_out_fall = -1;
    hs_out_rise = -1;
    for (int v = 0; v < 525; v++) begin
      len = (v == 479) ? 800 : ((v == 45) ? 64 : 22);
      for (int h = 0; h < len; h++)
        pix_step(h, v, (h >= 656 && h < 752) ? 1'b0 : 1'b1,
                 (v >= 490 && v < 492) ? 1'b0 : 1'b1, period);
    end
    check("frame_tick_count", 32'(tick_cnt), 32'd1);
    check("hs_low_steps", 32'(hs_low), 32'd96);
    check("vs_low_steps", 32'(vs_low), 32'd44);
    check("hs_fall_latency", 32'(hs_out_fall - hs_in_fall), 32'd2);
    check("hs_pulse_width", 32'(hs_out_rise - hs_out_fall), 32'd96);
  endtask

  // Per-clock comparison against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_q[0][11:0]));
      check("hs", 32'(vga_hs), 32'(exp_q[0][13]));
      check("vs", 32'(vga_vs), 32'(exp_q[0][12]));
      check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      check("frame_tick", 32'(frame_tick), 32'(exp_tick));
      if (frame_tick === 1'b1) tick_cnt++;
    end
  end

  initial begin
    chk_en   = 1'b0;
    frame_id = 0;
    step_cnt = 0;
    rst_n    = 1'b0;
    pix_en   = 1'b0;
    hcount   = 10'd0;
    vcount   = 10'd0;
    de_in    = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = 3'($urandom_range(0, 7));
    mem[0]   = 3'd6;
    mem[1]   = 3'd0;
    mem[65]  = 3'd2;
    mem[767] = 3'd3;
    model_reset();
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    // Prelude: put non-reset values on every output, then reset mid-line.
    for (int h = 0; h < 12; h++) pix_step(h, 0, 1'b1, 1'b1, 2);
    pix_step(12, 0, 1'b0, 1'b0, 2);
    pix_step(13, 0, 1'b0, 1'b0, 2);
    pix_step(0, 480, 1'b1, 1'b1, 1);
    check("pre_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0F0F);
    check("pre_hs", 32'(vga_hs), 32'd0);
    check("pre_vs", 32'(vga_vs), 32'd0);
    check("pre_tick", 32'(frame_tick), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("midrst_hs", 32'(vga_hs), 32'd1);
    check("midrst_vs", 32'(vga_vs), 32'd1);
    check("midrst_tick", 32'(frame_tick), 32'd0);
    check("midrst_addr", 32'(bus.mem_addr), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Frame 1: random board with pinned cells, pixel step every 2nd clock.
    run_frame(2, 1);
    // Frame 2: wall everywhere, pixel step every 4th clock.
    for (int a = 0; a < 1024; a++) mem[a] = 3'd4;
    run_frame(4, 2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
